ahb_rmw_ram_responder: RTL and testbench
========================================

Name: ahb_rmw_ram_responder

Overview:
- AHB-Lite subordinate that terminates the core's data bus; it is the memory-side counterpart of the LSU read-modify-write initiator.
- Backing store is one data word plus one parity bit per location, with no byte enables.
- Full-word writes commit directly. Byte and halfword writes are merged internally by a read-check-merge-write sequence.
- Parity errors, misaligned accesses, oversize accesses and out-of-range accesses return the AHB two-cycle ERROR response.

Parameters:
- MEM_AW, 10, log2 of the number of 32-bit words stored.
- BASE_ADDR, 32'h0, byte address of word 0; must be aligned to 4<<MEM_AW.

Ports:
- s_clk_i  in  1  clock.
- s_resetn_i  in  1  synchronous active-low reset.
- s_hsel_i  in  1  subordinate select.
- s_haddr_i  in  32  byte address.
- s_htrans_i  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ.
- s_hwrite_i  in  1  1=write.
- s_hsize_i  in  3  0=byte, 1=half, 2=word, >2 illegal.
- s_hwdata_i  in  32  write data, valid in data phase.
- s_hready_i  in  1  bus-level HREADY.
- s_hrdata_o  out  32  read data.
- s_hreadyout_o  out  1  subordinate ready.
- s_hresp_o  out  1  1=ERROR.
- s_perr_o  out  1  sticky flag: a parity mismatch was detected.
- s_perr_clr_i  in  1  clears s_perr_o.
- s_perr_inj_i  in  1  sampled at commit of a write; the stored parity bit is inverted (test hook).

Behaviour:
- Address-phase capture:
  - A transfer is accepted when s_hsel_i & s_htrans_i[1] & s_hready_i.
  - On acceptance, register offset = s_haddr_i - BASE_ADDR, hwrite, hsize and a byte-lane mask.
  - If nothing is accepted, the next state is IDLE.
- Legality is checked at address phase:
  - Illegal if hsize>2, or if the address is not aligned to size (half: addr[0]; word: addr[1:0]), or if offset >= 4<<MEM_AW.
  - An illegal transfer goes to ERR1. Memory and s_perr_o are unchanged.
- Parity: even parity over the 32 data bits. The stored bit is the XOR of all data bits, inverted when s_perr_inj_i=1 at commit.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, ERR1, ERR2. The target state is chosen at acceptance.
- IDLE:
  - Outputs hreadyout=1, hresp=0.
  - Legal read -> RD. Legal word write -> WR. Legal byte/half write -> RMW_RD.
- RD (data phase, zero wait):
  - The array is read combinationally at the registered word index; hrdata = stored word, whole word regardless of size.
  - Good parity: hreadyout=1, hresp=0.
  - Bad parity: hreadyout=0, hresp=1, set s_perr_o, go to ERR2. The data returned in that case is don't-care.
  - A new accepted transfer in the final ready cycle is pipelined (goes straight to its target state).
- WR (zero wait):
  - hreadyout=1; the word and its parity are written at the clock edge ending the cycle.
  - A following read of the same address returns the new data with no bypass.
- RMW_RD:
  - hreadyout=0; read the old word and check its parity.
  - Good parity: latch the old word, go to RMW_WR. Bad parity: set s_perr_o, go to ERR2 with hresp=1; no write.
- RMW_WR:
  - merged = (hwdata & lanemask) | (old & ~lanemask); write merged with its parity.
  - hreadyout=1.
  - Total: 1 wait state. s_hwdata_i must be held across both cycles (AHB rule).
- ERR1: hreadyout=0, hresp=1 -> ERR2.
- ERR2: hreadyout=1, hresp=1.
  - A transfer presented in ERR2 is accepted (s_hready_i=1); the manager may also cancel by driving IDLE.
- Lane masks:
  - byte: 8'hFF << 8*addr[1:0] on the data word.
  - half: 16'hFFFF << 16*addr[1].
  - Write data is taken from the matching HWDATA lanes (AHB lane convention, no shifting).
- s_perr_o:
  - Set on any detected mismatch; stays set until s_perr_clr_i=1.
  - If set and clear occur in the same cycle, set wins.
- Reset (s_resetn_i=0 at an edge):
  - State goes to IDLE; registered hwrite, hsize and lanemask are cleared to 0 (offset is not reset).
  - Outputs: hreadyout=1, hresp=0, s_perr_o=0, hrdata=0.
  - An in-flight write or RMW is dropped and memory is not modified.
  - Array contents are not reset; the bench must write a location before reading it.
- Non-selected transfers or IDLE/BUSY transfers in IDLE state: no action, hreadyout=1.

Test Plan:
- Word write 0x0000_0010 = 32'hDEADBEEF, then read it back-to-back -> zero-wait read returns DEADBEEF, hresp=0.
- Byte write 0xA5 to addr 0x11 over DEADBEEF -> one wait state (hreadyout 0 then 1); a later read returns DEADA5EF.
- Halfword write to 0x13 (misaligned) -> ERR1/ERR2 sequence (hresp=1 for 2 cycles, hreadyout 0 then 1); memory unchanged; s_perr_o stays 0.
- Word write 0x20 = 32'h1 with s_perr_inj_i=1, then read 0x20 -> two-cycle ERROR, s_perr_o=1. A byte write to 0x20 also errors without writing. s_perr_clr_i pulse -> s_perr_o=0.
- Read at offset 4<<MEM_AW (0x1000 for the default) and a transfer with hsize=3 -> ERROR responses.
- Assert reset during the RMW_RD cycle of a byte write -> next cycle hreadyout=1, hresp=0; the target word is unmodified on read-back.

Source files
------------

// File: rtl/ahb_rmw_ram_responder.sv
// AHB-Lite memory subordinate with per-word even parity. Byte/halfword writes
// are merged into the stored word by a read-check-merge-write sequence.
module ahb_rmw_ram_responder #(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [31:0] s_hwdata_i,
    input  logic        s_hready_i,
    output logic [31:0] s_hrdata_o,
    output logic        s_hreadyout_o,
    output logic        s_hresp_o,
    output logic        s_perr_o,
    input  logic        s_perr_clr_i,
    input  logic        s_perr_inj_i
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] offset_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [3:0]  lanemask_q;
    logic [31:0] old_q;
    logic        perr_q;

    logic [31:0] mem_data_q [DEPTH];
    logic        mem_par_q  [DEPTH];

    // Address-phase decode
    logic        accept;
    logic [31:0] offset_d;
    logic [3:0]  lanemask_d;
    logic        misaligned;
    logic        in_range;
    logic        legal;
    state_t      target;

    assign offset_d = s_haddr_i - BASE_ADDR;
    assign in_range = ~|offset_d[31:MEM_AW+2];

    always_comb begin
        lanemask_d = 4'b1111;
        misaligned = 1'b0;
        case (s_hsize_i)
            3'd0: lanemask_d = 4'b0001 << s_haddr_i[1:0];
            3'd1: begin
                lanemask_d = s_haddr_i[1] ? 4'b1100 : 4'b0011;
                misaligned = s_haddr_i[0];
            end
            3'd2: misaligned = |s_haddr_i[1:0];
            default: lanemask_d = 4'b1111;
        endcase
    end

    assign legal = (s_hsize_i <= 3'd2) && !misaligned && in_range;

    always_comb begin
        target = ST_ERR1;
        if (legal) begin
            if (!s_hwrite_i)             target = ST_RD;
            else if (s_hsize_i == 3'd2)  target = ST_WR;
            else                         target = ST_RMW_RD;
        end
    end

    // Array access at the registered word index
    logic [MEM_AW-1:0] word_idx;
    logic [31:0]       rd_data;
    logic              rd_par_ok;
    logic [31:0]       mask32;
    logic [31:0]       wr_data;

    assign word_idx  = offset_q[MEM_AW+1:2];
    assign rd_data   = mem_data_q[word_idx];
    assign rd_par_ok = ((^rd_data) == mem_par_q[word_idx]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign mask32[8*gi +: 8] = {8{lanemask_q[gi]}};
        end
    endgenerate

    // Word writes carry a full lane mask, so the merge degenerates to HWDATA.
    assign wr_data = (s_hwdata_i & mask32) | (old_q & ~mask32);

    // FSM next-state and outputs
    logic commit;
    logic perr_set;

    always_comb begin
        state_d       = ST_IDLE;
        s_hreadyout_o = 1'b1;
        s_hresp_o     = 1'b0;
        commit        = 1'b0;
        perr_set      = 1'b0;
        case (state_q)
            ST_RD: begin
                if (!rd_par_ok) begin
                    s_hreadyout_o = 1'b0;
                    s_hresp_o     = 1'b1;
                    perr_set      = 1'b1;
                end
            end
            ST_WR:     commit = 1'b1;
            ST_RMW_RD: begin
                s_hreadyout_o = 1'b0;
                if (!rd_par_ok) begin
                    s_hresp_o = 1'b1;
                    perr_set  = 1'b1;
                end
            end
            ST_RMW_WR: commit = 1'b1;
            ST_ERR1: begin
                s_hreadyout_o = 1'b0;
                s_hresp_o     = 1'b1;
            end
            ST_ERR2:   s_hresp_o = 1'b1;
            default:   s_hreadyout_o = 1'b1;
        endcase

        accept = s_hsel_i && s_htrans_i[1] && s_hready_i && s_hreadyout_o;

        if (perr_set)                   state_d = ST_ERR2;
        else if (state_q == ST_RMW_RD)  state_d = ST_RMW_WR;
        else if (state_q == ST_ERR1)    state_d = ST_ERR2;
        else if (accept)                state_d = target;
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state_q    <= ST_IDLE;
            hwrite_q   <= 1'b0;
            hsize_q    <= 3'd0;
            lanemask_q <= 4'd0;
            perr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                hwrite_q   <= s_hwrite_i;
                hsize_q    <= s_hsize_i;
                lanemask_q <= lanemask_d;
            end
            if (perr_set)          perr_q <= 1'b1;
            else if (s_perr_clr_i) perr_q <= 1'b0;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (accept) begin
            offset_q <= offset_d;
        end
        if (state_q == ST_RMW_RD && rd_par_ok) begin
            old_q <= rd_data;
        end
    end

    // A reset in the commit cycle drops the write.
    always_ff @(posedge s_clk_i) begin
        if (commit && hwrite_q && s_resetn_i) begin
            mem_data_q[word_idx] <= wr_data;
            mem_par_q[word_idx]  <= (^wr_data) ^ s_perr_inj_i;
        end
    end

    assign s_hrdata_o = (state_q == ST_RD) ? rd_data : 32'h0;
    assign s_perr_o   = perr_q;

    logic unused_bits;
    assign unused_bits = ^{offset_q[31:MEM_AW+2], offset_q[1:0], hsize_q};

endmodule

// File: tb/tb_ahb_rmw_ram_responder.sv
// Directed bench for ahb_rmw_ram_responder: a vector table of single transfers
// plus hand-written pipelined and reset-during-RMW sequences.
module tb_ahb_rmw_ram_responder;

    logic        clk;
    logic        resetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    wire         hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        perr;
    logic        perr_clr;
    logic        perr_inj;

    int checks = 0;
    int errors = 0;

    assign hready = hreadyout;

    ahb_rmw_ram_responder #(.MEM_AW(10), .BASE_ADDR(32'h0)) dut (
        .s_clk_i       (clk),
        .s_resetn_i    (resetn),
        .s_hsel_i      (hsel),
        .s_haddr_i     (haddr),
        .s_htrans_i    (htrans),
        .s_hwrite_i    (hwrite),
        .s_hsize_i     (hsize),
        .s_hwdata_i    (hwdata),
        .s_hready_i    (hready),
        .s_hrdata_o    (hrdata),
        .s_hreadyout_o (hreadyout),
        .s_hresp_o     (hresp),
        .s_perr_o      (perr),
        .s_perr_clr_i  (perr_clr),
        .s_perr_inj_i  (perr_inj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        inj;
        logic        clr;
        logic        exp_resp;
        int          exp_waits;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [2:0] sz, logic [31:0] addr, logic [31:0] wd,
                                logic inj, logic clr, logic exp_resp, int exp_waits,
                                logic chk_rd, logic [31:0] exp_rd, logic exp_perr);
        vec_t v;
        v.wr = wr; v.sz = sz; v.addr = addr; v.wd = wd; v.inj = inj; v.clr = clr;
        v.exp_resp = exp_resp; v.exp_waits = exp_waits; v.chk_rd = chk_rd;
        v.exp_rd = exp_rd; v.exp_perr = exp_perr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // One non-pipelined transfer: address phase, then data phase until ready.
    task automatic run_xfer(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic inj, input logic clr,
                            output int waits, output logic resp, output logic [31:0] rdata,
                            output logic perr_v);
        logic done;
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz;
        perr_clr = clr; perr_inj = 1'b0; hwdata = 32'h0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; perr_clr = 1'b0; hwdata = wd; perr_inj = inj;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (hreadyout) done = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        resp   = hresp;
        rdata  = hrdata;
        perr_v = perr;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout addr %h: got hreadyout %0b, expected 1", addr, hreadyout);
        end
    endtask

    initial begin
        int          w;
        logic        r;
        logic [31:0] d;
        logic        p;

        resetn = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hwdata = 32'h0; perr_clr = 1'b0; perr_inj = 1'b0;

        vecs.push_back(mk(1, 2, 32'h10,   32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 2, 32'h10,   32'h0,        0, 0, 0, 0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 0, 32'h11,   32'h0000A500, 0, 0, 0, 1, 0, 32'h0,        0));
        vecs.push_back(mk(0, 2, 32'h10,   32'h0,        0, 0, 0, 0, 1, 32'hDEADA5EF, 0));
        vecs.push_back(mk(1, 1, 32'h13,   32'h12345678, 0, 0, 1, 1, 0, 32'h0,        0));
        vecs.push_back(mk(0, 2, 32'h10,   32'h0,        0, 0, 0, 0, 1, 32'hDEADA5EF, 0));
        vecs.push_back(mk(0, 1, 32'h12,   32'h0,        0, 0, 0, 0, 1, 32'hDEADA5EF, 0));
        vecs.push_back(mk(1, 2, 32'h14,   32'h55667788, 0, 0, 0, 0, 0, 32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h16,   32'hABCD0000, 0, 0, 0, 1, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h17,   32'h99000000, 0, 0, 0, 1, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h15,   32'h0,        0, 0, 0, 0, 1, 32'h99CD7788, 0));
        vecs.push_back(mk(1, 2, 32'h22,   32'hFFFFFFFF, 0, 0, 1, 1, 0, 32'h0,        0));
        vecs.push_back(mk(1, 2, 32'hFFC,  32'hCAFEF00D, 0, 0, 0, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 2, 32'hFFC,  32'h0,        0, 0, 0, 0, 1, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 2, 32'h20,   32'h00000001, 1, 0, 0, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 2, 32'h20,   32'h0,        0, 0, 1, 1, 0, 32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h20,   32'h000000FF, 0, 0, 1, 1, 0, 32'h0,        1));
        vecs.push_back(mk(0, 2, 32'h1000, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0));
        vecs.push_back(mk(0, 3, 32'h0,    32'h0,        0, 0, 1, 1, 0, 32'h0,        0));
        vecs.push_back(mk(1, 2, 32'h20,   32'h00000077, 0, 0, 0, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 2, 32'h20,   32'h0,        0, 0, 0, 0, 1, 32'h00000077, 0));
        vecs.push_back(mk(0, 2, 32'h10,   32'h0,        0, 0, 0, 0, 1, 32'hDEADA5EF, 0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hreadyout", 0, {31'h0, hreadyout}, 32'h1);
        chk("reset_hresp",     0, {31'h0, hresp},     32'h0);
        chk("reset_perr",      0, {31'h0, perr},      32'h0);
        chk("reset_hrdata",    0, hrdata,             32'h0);
        resetn = 1'b1;

        // Table of single transfers
        for (int i = 0; i < vecs.size(); i++) begin
            run_xfer(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].inj,
                     vecs[i].clr, w, r, d, p);
            $display("vec %0d: %s sz=%0d addr=%h wd=%h -> waits=%0d resp=%0b rdata=%h perr=%0b",
                     i, vecs[i].wr ? "WR" : "RD", vecs[i].sz, vecs[i].addr, vecs[i].wd, w, r, d, p);
            chk("waits", i, w, vecs[i].exp_waits);
            chk("hresp", i, {31'h0, r}, {31'h0, vecs[i].exp_resp});
            chk("perr",  i, {31'h0, p}, {31'h0, vecs[i].exp_perr});
            if (vecs[i].chk_rd) chk("hrdata", i, d, vecs[i].exp_rd);
        end

        // Pipelined write then read of the same word, no bypass needed
        @(posedge clk); #1;
        perr_inj = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'h0BADF00D; haddr = 32'h30; hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_wr_ready", 100, {31'h0, hreadyout}, 32'h1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        $display("b2b: read 0x30 -> hrdata=%h ready=%0b resp=%0b", hrdata, hreadyout, hresp);
        chk("b2b_rd_data",  101, hrdata, 32'h0BADF00D);
        chk("b2b_rd_ready", 101, {31'h0, hreadyout}, 32'h1);
        chk("b2b_rd_resp",  101, {31'h0, hresp}, 32'h0);

        // Reset during the RMW_RD cycle of a byte write
        run_xfer(1, 2, 32'h40, 32'h11223344, 0, 0, w, r, d, p);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h000000FF;
        @(negedge clk);
        chk("rmw_rd_wait", 200, {31'h0, hreadyout}, 32'h0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        $display("rst_rmw: after reset ready=%0b resp=%0b", hreadyout, hresp);
        chk("rst_rmw_ready", 201, {31'h0, hreadyout}, 32'h1);
        chk("rst_rmw_resp",  201, {31'h0, hresp}, 32'h0);
        run_xfer(0, 2, 32'h40, 32'h0, 0, 0, w, r, d, p);
        $display("rst_rmw: read 0x40 -> hrdata=%h resp=%0b", d, r);
        chk("rst_rmw_data", 202, d, 32'h11223344);
        chk("rst_rmw_rresp", 202, {31'h0, r}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
